// File: rtl/regfile_write_arbiter_if.sv
// Bundles the requester, register-file write and scoreboard signals of the write arbiter.
// The slave modport is the arbiter's view; master is the producer/decode/register-file side.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_reg;
    logic [NUM_REQ*DATA_WIDTH-1:0]     req_data;
    logic                              rf_write;
    logic [REG_ADDR_WIDTH-1:0]         rf_write_reg_num;
    logic [DATA_WIDTH-1:0]             rf_write_data;
    logic                              reserve_valid;
    logic [REG_ADDR_WIDTH-1:0]         reserve_reg;
    logic                              reserve_ready;
    logic [7:0]                        busy;

    modport slave (
        input  req_valid, req_reg, req_data, reserve_valid, reserve_reg,
        output req_ready, rf_write, rf_write_reg_num, rf_write_data, reserve_ready, busy
    );

    modport master (
        output req_valid, req_reg, req_data, reserve_valid, reserve_reg,
        input  req_ready, rf_write, rf_write_reg_num, rf_write_data, reserve_ready, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a registered
// write stage and a destination-register scoreboard used by decode for WAW/RAW stalls.
module regfile_write_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int SUM_W = PTR_W + 1;

    logic [PTR_W-1:0]          r_ptr;
    logic                      r_rf_write;
    logic [REG_ADDR_WIDTH-1:0] r_rf_reg;
    logic [DATA_WIDTH-1:0]     r_rf_data;
    logic [7:0]                r_busy;

    logic [SUM_W-1:0]          w_idx;
    logic [PTR_W-1:0]          w_win;
    logic [PTR_W-1:0]          w_ptr_nxt;
    logic                      w_xfer;
    logic [NUM_REQ-1:0]        w_grant;
    logic [REG_ADDR_WIDTH-1:0] w_win_reg;
    logic [DATA_WIDTH-1:0]     w_win_data;
    logic                      w_release;
    logic                      w_reserve_ok;
    logic [7:0]                w_busy_nxt;

    // Search from r_ptr upward, wrapping modulo NUM_REQ; first valid requester wins.
    always_comb begin
        w_grant = '0;
        w_xfer  = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + SUM_W'(k);
            if (w_idx >= SUM_W'(NUM_REQ)) begin
                w_idx = w_idx - SUM_W'(NUM_REQ);
            end
            if (!w_xfer && bus.req_valid[w_idx[PTR_W-1:0]]) begin
                w_xfer = 1'b1;
                w_win  = w_idx[PTR_W-1:0];
            end
        end
        if (w_xfer) begin
            w_grant[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_win_reg  = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_reg  = bus.req_reg[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                w_win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);

    // A register being released by this cycle's commit may be re-reserved immediately.
    assign w_release    = r_rf_write && (r_rf_reg == bus.reserve_reg);
    assign w_reserve_ok = bus.reserve_valid && (!r_busy[bus.reserve_reg] || w_release);

    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rf_write) begin
            w_busy_nxt[r_rf_reg] = 1'b0;
        end
        if (w_reserve_ok) begin
            w_busy_nxt[bus.reserve_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_rf_write <= 1'b0;
            r_rf_reg   <= '0;
            r_rf_data  <= '0;
            r_busy     <= '0;
        end else begin
            r_rf_write <= w_xfer;
            r_busy     <= w_busy_nxt;
            if (w_xfer) begin
                r_ptr     <= w_ptr_nxt;
                r_rf_reg  <= w_win_reg;
                r_rf_data <= w_win_data;
            end
        end
    end

    assign bus.req_ready        = w_grant;
    assign bus.rf_write         = r_rf_write;
    assign bus.rf_write_reg_num = r_rf_reg;
    assign bus.rf_write_data    = r_rf_data;
    assign bus.reserve_ready    = w_reserve_ok;
    assign bus.busy             = r_busy;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of arbitration and scoreboard.
module tb_regfile_write_arbiter;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus();

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int         m_ptr;
    logic       m_rfw;
    logic [2:0] m_reg;
    logic [15:0] m_data;
    logic [7:0] m_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_rfw  = 1'b0;
        m_reg  = '0;
        m_data = '0;
        m_busy = '0;
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_state();
        check("rf_write", 32'(bus.rf_write), 32'(m_rfw));
        check("rf_reg", 32'(bus.rf_write_reg_num), 32'(m_reg));
        check("rf_data", 32'(bus.rf_write_data), 32'(m_data));
        check("busy", 32'(bus.busy), 32'(m_busy));
    endtask

    // One clock: check combinational and registered outputs, advance the model, take the edge.
    task automatic step(output int gw);
        logic       exp_rr;
        logic [7:0] nb;
        int         rr;
        #1;
        gw = model_winner();
        check("req_ready", 32'(bus.req_ready), (gw < 0) ? 32'd0 : (32'd1 << gw));
        rr = int'(bus.reserve_reg);
        exp_rr = bus.reserve_valid && (!m_busy[rr] || (m_rfw && int'(m_reg) == rr));
        check("reserve_ready", 32'(bus.reserve_ready), 32'(exp_rr));
        check_state();
        nb = m_busy;
        if (m_rfw) nb[m_reg] = 1'b0;
        if (exp_rr) nb[rr] = 1'b1;
        m_busy = nb;
        if (gw >= 0) begin
            m_rfw  = 1'b1;
            m_reg  = bus.req_reg[gw*AW +: AW];
            m_data = bus.req_data[gw*DW +: DW];
            m_ptr  = (gw + 1) % N;
        end else begin
            m_rfw = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] r, input logic [15:0] d);
        bus.req_valid[i]         = v;
        bus.req_reg[i*AW +: AW]  = r;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic idle_inputs();
        bus.req_valid     = '0;
        bus.req_reg       = '0;
        bus.req_data      = '0;
        bus.reserve_valid = 1'b0;
        bus.reserve_reg   = '0;
    endtask

    initial begin
        int gw;
        idle_inputs();
        model_reset();
        #1;
        check_state();
        #20;
        rst_n = 1'b1;

        // Fill the scoreboard, with a write in flight on the last cycle, then reset.
        for (int r = 0; r < 8; r++) begin
            bus.reserve_valid = 1'b1;
            bus.reserve_reg   = 3'(r);
            if (r == 7) begin
                for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(i), 16'hA000 + 16'(i));
            end
            step(gw);
        end
        check("busy_full", 32'(bus.busy), 32'hFF);
        check("wr_inflight", 32'(bus.rf_write), 32'd1);
        #2;
        rst_n = 1'b0;
        bus.req_valid = 3'b111;
        #1;
        model_reset();
        check("rst_rf_write", 32'(bus.rf_write), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ptr", 32'(bus.req_ready), 32'b001);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(gw);

        // Round-robin with all three requesting.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(i + 1), 16'(16'h1000 * (k + 1) + i));
            step(gw);
            check("rr_order", 32'(gw), 32'(k % 3));
        end
        idle_inputs();
        step(gw);

        // Single request from requester 1.
        set_req(1, 1'b1, 3'd5, 16'hBEEF);
        #1;
        check("single_ready", 32'(bus.req_ready), 32'b010);
        step(gw);
        idle_inputs();
        check("single_wr", 32'(bus.rf_write), 32'd1);
        check("single_reg", 32'(bus.rf_write_reg_num), 32'd5);
        check("single_data", 32'(bus.rf_write_data), 32'hBEEF);
        step(gw);
        check("single_done", 32'(bus.rf_write), 32'd0);

        // Grant 2, idle, then 0 and 2 compete.
        set_req(2, 1'b1, 3'd2, 16'h2222);
        step(gw);
        check("fair_g2", 32'(gw), 32'd2);
        idle_inputs();
        for (int k = 0; k < 3; k++) step(gw);
        set_req(0, 1'b1, 3'd0, 16'h0000);
        set_req(2, 1'b1, 3'd2, 16'h2223);
        step(gw);
        check("fair_g0", 32'(gw), 32'd0);
        set_req(0, 1'b0, 3'd0, 16'h0000);
        step(gw);
        check("fair_g2b", 32'(gw), 32'd2);
        idle_inputs();
        step(gw);

        // Scoreboard reserve, WAW stall, release-bypass.
        bus.reserve_valid = 1'b1;
        bus.reserve_reg   = 3'd3;
        step(gw);
        check("sb_set", 32'(bus.busy), 32'h08);
        #1;
        check("sb_waw", 32'(bus.reserve_ready), 32'd0);
        bus.reserve_valid = 1'b0;
        set_req(0, 1'b1, 3'd3, 16'h3333);
        step(gw);
        idle_inputs();
        bus.reserve_valid = 1'b1;
        bus.reserve_reg   = 3'd3;
        #1;
        check("sb_bypass", 32'(bus.reserve_ready), 32'd1);
        step(gw);
        check("sb_keep", 32'(bus.busy), 32'h08);

        // Independent set and clear.
        idle_inputs();
        set_req(0, 1'b1, 3'd3, 16'h3334);
        step(gw);
        idle_inputs();
        bus.reserve_valid = 1'b1;
        bus.reserve_reg   = 3'd6;
        step(gw);
        check("sb_r6", 32'(bus.busy), 32'h40);
        idle_inputs();
        set_req(0, 1'b1, 3'd6, 16'h6666);
        step(gw);
        idle_inputs();
        bus.reserve_valid = 1'b1;
        bus.reserve_reg   = 3'd1;
        step(gw);
        check("sb_indep", 32'(bus.busy), 32'h02);

        // Randomized traffic; ungranted requesters hold their request.
        idle_inputs();
        gw = -1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(bus.req_valid[i] && i != gw)) begin
                    set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
                end
            end
            bus.reserve_valid = 1'($urandom_range(0, 1));
            bus.reserve_reg   = 3'($urandom_range(0, 7));
            step(gw);
        end
        idle_inputs();
        step(gw);
        check_state();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
